// File: rtl/obstacle_spawner.sv
// Multi-obstacle scroll/spawn engine: clock-divided scroll steps, chained respawn behind the tail.
// Optional speed ramp is enabled by defining OBST_SPEED_RAMP_EN.
module obstacle_spawner #(
    parameter int NUM_OBST     = 4,
    parameter int POS_W        = 12,
    parameter int RAND_W       = 9,
    parameter int EXIT_X       = 1074,
    parameter int SPAWN_MAX_X  = -50,
    parameter int MIN_GAP      = 1024,
    parameter int INIT_X       = 300,
    parameter int INIT_SPACING = 600,
    parameter int START_DIV    = 200000,
    parameter int MIN_DIV      = 50000,
    parameter int DIV_STEP     = 10000,
    parameter int RAMP_PERIOD  = 180000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      game_over,
    input  logic [RAND_W-1:0]         rand_in,
    output logic [NUM_OBST*POS_W-1:0] obst_pos,
    output logic                      step_pulse,
    output logic [3:0]                speed_lvl
);

    localparam int DIV_W  = $clog2(START_DIV + 1);
    localparam int TAIL_W = $clog2(NUM_OBST);
    localparam int CW     = POS_W + RAND_W + 1;

    typedef logic signed [POS_W-1:0] pos_t;

    localparam pos_t                 EXIT_C = POS_W'(EXIT_X);
    localparam logic signed [CW-1:0] GAP_C  = CW'(MIN_GAP);
    localparam logic signed [CW-1:0] SMAX_C = CW'(SPAWN_MAX_X);
    localparam logic signed [CW-1:0] SAT_C  = CW'(-(2 ** (POS_W - 1)));

    if (NUM_OBST < 2 || NUM_OBST > 8 || MIN_DIV < 1 || DIV_STEP < 1 || RAMP_PERIOD < 2)
    begin : g_bad_cfg
        $error("obstacle_spawner: unsupported parameter set");
    end

    pos_t                 pos_q   [NUM_OBST];
    pos_t                 pos_d   [NUM_OBST];
    pos_t                 inc_pos [NUM_OBST];
    pos_t                 tail_val;
    logic signed [CW-1:0] tv_ext;
    logic signed [CW-1:0] rnd_ext;
    logic signed [CW-1:0] cand;
    logic [TAIL_W-1:0]    tail_q, tail_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [3:0]           speed_lvl_q, speed_lvl_d;
    logic                 step_pulse_q;
    logic                 step_now;

    // div_q >= 1 always; >= also catches a count left above a freshly shrunk divider.
    assign step_now = !game_over && (div_cnt_q >= div_q - 1'b1);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!game_over) begin
            div_cnt_d = step_now ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Respawns are chained in ascending slot order: each new slot becomes the reference tail.
    always_comb begin
        pos_d    = pos_q;
        tail_d   = tail_q;
        rnd_ext  = CW'(rand_in);
        tv_ext   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_OBST; i++) begin
            inc_pos[i] = pos_q[i] + pos_t'(1);
        end
        tail_val = inc_pos[tail_q];
        if (step_now) begin
            for (int i = 0; i < NUM_OBST; i++) begin
                pos_d[i] = inc_pos[i];
                if (inc_pos[i] == EXIT_C) begin
                    tv_ext = tail_val;
                    cand   = tv_ext - GAP_C - rnd_ext;
                    if (cand > SMAX_C) cand = SMAX_C;
                    if (cand < SAT_C)  cand = SAT_C;
                    pos_d[i] = cand[POS_W-1:0];
                    tail_val = cand[POS_W-1:0];
                    tail_d   = TAIL_W'(i);
                end
            end
        end
    end

`ifdef OBST_SPEED_RAMP_EN
    localparam int RAMP_W = $clog2(RAMP_PERIOD);

    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;

    // A ramp that coincides with a step only changes the divider seen from the next cycle.
    always_comb begin
        ramp_cnt_d  = ramp_cnt_q;
        div_d       = div_q;
        speed_lvl_d = speed_lvl_q;
        if (!game_over) begin
            if (ramp_cnt_q == RAMP_W'(RAMP_PERIOD - 1)) begin
                ramp_cnt_d = '0;
                if (div_q > DIV_W'(MIN_DIV)) begin
                    if (int'(div_q) - DIV_STEP > MIN_DIV) begin
                        div_d = div_q - DIV_W'(DIV_STEP);
                    end else begin
                        div_d = DIV_W'(MIN_DIV);
                    end
                    if (speed_lvl_q != 4'd15) begin
                        speed_lvl_d = speed_lvl_q + 4'd1;
                    end
                end
            end else begin
                ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_cnt_q <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
        end
    end
`else
    always_comb begin
        div_d       = DIV_W'(START_DIV);
        speed_lvl_d = 4'd0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBST; i++) begin
                pos_q[i] <= POS_W'(INIT_X - i * INIT_SPACING);
            end
            tail_q       <= TAIL_W'(NUM_OBST - 1);
            div_q        <= DIV_W'(START_DIV);
            div_cnt_q    <= '0;
            speed_lvl_q  <= 4'd0;
            step_pulse_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            tail_q       <= tail_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            speed_lvl_q  <= speed_lvl_d;
            step_pulse_q <= step_now;
        end
    end

    for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_pack
        assign obst_pos[gi*POS_W +: POS_W] = pos_q[gi];
    end

    assign step_pulse = step_pulse_q;
    assign speed_lvl  = speed_lvl_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner using a step-level reference model.
// Follows OBST_SPEED_RAMP_EN so the same bench covers both builds.
module tb_obstacle_spawner;

    localparam int NO = 2, PW = 12, RW = 9;
    localparam int EXIT = 20, SMAX = -5, GAP = 10, IX = 15, IS = 8;
    localparam int SD = 4, MD = 2, DS = 1, RP = 40;
`ifdef OBST_SPEED_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             game_over = 1'b0;
    logic [RW-1:0]    rand_in = '0;
    logic [NO*PW-1:0] obst_pos;
    logic             step_pulse;
    logic [3:0]       speed_lvl;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_pos [NO];
    int m_tail, m_div, m_cnt, m_ramp, m_lvl, n_steps;
    bit m_pulse;

    obstacle_spawner #(
        .NUM_OBST(NO), .POS_W(PW), .RAND_W(RW), .EXIT_X(EXIT), .SPAWN_MAX_X(SMAX),
        .MIN_GAP(GAP), .INIT_X(IX), .INIT_SPACING(IS), .START_DIV(SD),
        .MIN_DIV(MD), .DIV_STEP(DS), .RAMP_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .game_over(game_over), .rand_in(rand_in),
        .obst_pos(obst_pos), .step_pulse(step_pulse), .speed_lvl(speed_lvl)
    );

    always #5 clk = ~clk;

    function automatic logic [NO*PW-1:0] exp_bus();
        logic [NO*PW-1:0] b;
        for (int i = 0; i < NO; i++) b[i*PW +: PW] = PW'(m_pos[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NO; i++) m_pos[i] = IX - i * IS;
        m_tail = NO - 1; m_div = SD; m_cnt = 0; m_ramp = 0; m_lvl = 0;
        m_pulse = 0; n_steps = 0;
    endtask

    task automatic model_scroll();
        int np [NO];
        int tv, c;
        for (int i = 0; i < NO; i++) np[i] = m_pos[i] + 1;
        tv = np[m_tail];
        for (int i = 0; i < NO; i++) begin
            if (np[i] == EXIT) begin
                c = tv - (GAP + int'(rand_in));
                if (c > SMAX) c = SMAX;
                if (c < -(2 ** (PW - 1))) c = -(2 ** (PW - 1));
                np[i] = c; tv = c; m_tail = i;
            end
        end
        for (int i = 0; i < NO; i++) m_pos[i] = np[i];
    endtask

    task automatic model_edge();
        bit do_step;
        int nd;
        if (rst) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (!game_over) begin
                do_step = (m_cnt >= m_div - 1);
                nd = m_div;
                if (RAMP_EN) begin
                    if (m_ramp == RP - 1) begin
                        m_ramp = 0;
                        if (m_div > MD) begin
                            nd = (m_div - DS > MD) ? m_div - DS : MD;
                            if (m_lvl < 15) m_lvl++;
                        end
                    end else begin
                        m_ramp++;
                    end
                end
                if (do_step) begin
                    model_scroll();
                    m_cnt = 0; m_pulse = 1; n_steps++;
                end else begin
                    m_cnt++;
                end
                m_div = nd;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (m_pulse)
            $display("step %0d: slot0=%0d slot1=%0d tail=%0d lvl=%0d",
                     n_steps, m_pos[0], m_pos[1], m_tail, m_lvl);
    endtask

    task automatic test_reset();
        logic [NO*PW-1:0] want;
        want = {12'd7, 12'd15};
        rst = 1'b1; game_over = 1'b0;
        tick();
        checks++;
        if (obst_pos !== want || step_pulse !== 1'b0 || speed_lvl !== 4'd0) begin
            failures++;
            $display("FAIL reset: pos=%h pulse=%b lvl=%0d, required pos=%h pulse=0 lvl=0",
                     obst_pos, step_pulse, speed_lvl, want);
        end
        rst = 1'b0;
    endtask

    task automatic test_scroll_respawn();
        int edges = 0;
        bit seen_first = 0, done13 = 0;
        logic [NO*PW-1:0] want_first;
        want_first = {12'd8, 12'd16};
        rand_in = 9'd3;
        for (int k = 0; k < 80 && !done13; k++) begin
            tick(); edges++;
            checks++;
            if (obst_pos !== exp_bus() || step_pulse !== m_pulse || speed_lvl !== 4'(m_lvl)) begin
                failures++;
                $display("FAIL scroll cyc%0d: pos=%h pulse=%b lvl=%0d, required pos=%h pulse=%b lvl=%0d",
                         edges, obst_pos, step_pulse, speed_lvl, exp_bus(), m_pulse, m_lvl);
            end
            if (step_pulse === 1'b1 && !seen_first) begin
                seen_first = 1;
                checks++;
                if (edges != 4 || obst_pos !== want_first) begin
                    failures++;
                    $display("FAIL first_step: edge=%0d pos=%h, required edge=4 pos=%h",
                             edges, obst_pos, want_first);
                end
            end
            if (m_pulse && n_steps == 5) begin
                checks++;
                if ($signed(obst_pos[11:0]) !== -12'sd5) begin
                    failures++;
                    $display("FAIL respawn0: slot0=%0d, required -5", $signed(obst_pos[11:0]));
                end
                rand_in = 9'd0;
            end
            if (m_pulse && n_steps == 13) begin
                done13 = 1;
                checks++;
                if ($signed(obst_pos[23:12]) !== -12'sd7 || $signed(obst_pos[11:0]) !== 12'sd3) begin
                    failures++;
                    $display("FAIL respawn1: slot1=%0d slot0=%0d, required -7 and 3",
                             $signed(obst_pos[23:12]), $signed(obst_pos[11:0]));
                end
            end
        end
        if (!done13) begin
            checks++; failures++;
            $display("FAIL scroll_timeout: steps=%0d, required 13 within 80 cycles", n_steps);
        end
    endtask

    task automatic test_game_over();
        for (int k = 0; k < 90; k++) begin
            rand_in = RW'($urandom);
            game_over = (k >= 10 && k < 60);
            tick();
            checks++;
            if (obst_pos !== exp_bus() || step_pulse !== m_pulse || speed_lvl !== 4'(m_lvl)) begin
                failures++;
                $display("FAIL game_over k%0d: pos=%h pulse=%b lvl=%0d, required pos=%h pulse=%b lvl=%0d",
                         k, obst_pos, step_pulse, speed_lvl, exp_bus(), m_pulse, m_lvl);
            end
        end
        game_over = 1'b0;
    endtask

    task automatic test_ramp();
        int last_p = -1, period = -1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            rand_in = RW'($urandom);
            tick();
            checks++;
            if (obst_pos !== exp_bus() || step_pulse !== m_pulse || speed_lvl !== 4'(m_lvl)) begin
                failures++;
                $display("FAIL ramp cyc%0d: pos=%h pulse=%b lvl=%0d, required pos=%h pulse=%b lvl=%0d",
                         k, obst_pos, step_pulse, speed_lvl, exp_bus(), m_pulse, m_lvl);
            end
            if (step_pulse === 1'b1) begin
                if (last_p >= 0) period = k - last_p;
                last_p = k;
            end
        end
        checks++;
        if (speed_lvl !== (RAMP_EN ? 4'd2 : 4'd0) || period != (RAMP_EN ? 2 : 4)) begin
            failures++;
            $display("FAIL ramp_final: lvl=%0d period=%0d, required lvl=%0d period=%0d",
                     speed_lvl, period, RAMP_EN ? 2 : 0, RAMP_EN ? 2 : 4);
        end
    endtask

    task automatic test_reset_mid_step();
        logic [NO*PW-1:0] want;
        bit hit = 0;
        want = {12'd7, 12'd15};
        for (int k = 0; k < 20 && !hit; k++) begin
            if (m_cnt >= m_div - 1) begin
                hit = 1;
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        checks++;
        if (!hit || obst_pos !== want || step_pulse !== 1'b0 || speed_lvl !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_step: hit=%0d pos=%h pulse=%b lvl=%0d, required pos=%h pulse=0 lvl=0",
                     hit, obst_pos, step_pulse, speed_lvl, want);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            rand_in = RW'($urandom);
            game_over = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (obst_pos !== exp_bus() || step_pulse !== m_pulse || speed_lvl !== 4'(m_lvl)) begin
                failures++;
                $display("FAIL random k%0d: pos=%h pulse=%b lvl=%0d, required pos=%h pulse=%b lvl=%0d",
                         k, obst_pos, step_pulse, speed_lvl, exp_bus(), m_pulse, m_lvl);
            end
        end
        game_over = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scroll_respawn();
        test_game_over();
        test_ramp();
        test_reset_mid_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
